// File: rtl/mem_readout_streamer.sv
// Walks an address window of the processor data memory and hands each word
// to an external host over a 4-phase valid/ack handshake.
module mem_readout_streamer #(
  parameter int ADDR_W        = 24,
  parameter int DATA_W        = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       word_count,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ack,
  output logic              busy,
  output logic              done,
  output logic [15:0]       words_sent
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_SETTLE  = 3'd3;
  localparam logic [2:0] S_REQ     = 3'd4;
  localparam logic [2:0] S_ACKLO   = 3'd5;
  localparam logic [2:0] S_FIN     = 3'd6;

  logic [2:0]  state;
  logic [15:0] remaining;
  logic [3:0]  settle_cnt;
  logic        ack_sync_p0;
  logic        ack_sync_p1;

  // Two-flop synchroniser for the host's asynchronous acknowledge
  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_sync_p0 <= 1'b0;
      ack_sync_p1 <= 1'b0;
    end else begin
      ack_sync_p0 <= out_ack;
      ack_sync_p1 <= ack_sync_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      mem_addr   <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      words_sent <= '0;
      remaining  <= '0;
      settle_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (word_count != 16'd0) begin
              mem_addr   <= base_addr;
              remaining  <= word_count;
              words_sent <= '0;
              busy       <= 1'b1;
              state      <= S_ADDR;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_ADDR: begin
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          out_data   <= mem_q;
          settle_cnt <= 4'(SETTLE_CYCLES);
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          // Valid rises on the edge where the counter reaches zero
          settle_cnt <= settle_cnt - 4'd1;
          if (settle_cnt == 4'd1) begin
            out_valid <= 1'b1;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (ack_sync_p1) begin
            out_valid  <= 1'b0;
            words_sent <= words_sent + 16'd1;
            remaining  <= remaining - 16'd1;
            state      <= S_ACKLO;
          end
        end
        S_ACKLO: begin
          if (!ack_sync_p1) begin
            if (remaining == 16'd0) begin
              state <= S_FIN;
            end else begin
              mem_addr <= mem_addr + ADDR_W'(1);
              state    <= S_ADDR;
            end
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
